// File: rtl/bit4_downcounter.sv
// Loadable down-counter with underflow pulse and a start/pause/ack handshake.
// Acts as a programmable countdown or timeout source beside the up-counter.
module bit4_downcounter #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    input  logic             ack,
    output logic [WIDTH-1:0] counter,
    output logic             underflow,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             underflow_q, underflow_d;
    logic             done_q, done_d;

    // Load overrides everything; ack only matters once the count has expired.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        underflow_d = 1'b0;
        done_d      = done_q;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = IDLE;
            done_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) state_d = RUN;
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (count_q != '0) begin
                        count_d = count_q - ONE;
                    end else begin
                        // Expiry edge: the counter is already 0, so it never wraps.
                        underflow_d = 1'b1;
                        if (AUTO_RELOAD) begin
                            count_d = reload_q;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (!pause) state_d = RUN;
                end
                DONE: begin
                    if (ack) begin
                        state_d = IDLE;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            underflow_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            underflow_q <= underflow_d;
            done_q      <= done_d;
        end
    end

    assign counter   = count_q;
    assign underflow = underflow_q;
    assign done      = done_q;
    assign busy      = (state_q == RUN) || (state_q == PAUSE);

endmodule

// File: tb/tb_bit4_downcounter.sv
// Scoreboard bench for bit4_downcounter: one instance without and one with auto-reload.
module tb_bit4_downcounter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       ack = 1'b0;

    logic [3:0] counter0, counter1;
    logic       uf0, uf1, busy0, busy1, done0, done1;

    typedef struct packed {
        logic [3:0] cnt;
        logic       uf;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct packed {
        logic       ld;
        logic [3:0] lv;
        logic       st;
        logic       ps;
        logic       ak;
    } stim_t;

    stim_t stimQ[$];
    obs_t  planQ[$];
    obs_t  expQ[$];
    int    checks = 0;
    int    passed = 0;

    bit4_downcounter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .ack(ack),
        .counter(counter0), .underflow(uf0), .busy(busy0), .done(done0)
    );

    bit4_downcounter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .ack(ack),
        .counter(counter1), .underflow(uf1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    function automatic obs_t obs(input bit sel);
        if (sel) return obs_t'({counter1, uf1, busy1, done1});
        return obs_t'({counter0, uf0, busy0, done0});
    endfunction

    // One cycle of stimulus plus the outputs expected right after that edge.
    function automatic void plan(input logic ld, input logic [3:0] lv, input logic st,
                                 input logic ps, input logic ak, input logic [3:0] cnt,
                                 input logic uf, input logic bz, input logic dn);
        stimQ.push_back(stim_t'({ld, lv, st, ps, ak}));
        planQ.push_back(obs_t'({cnt, uf, bz, dn}));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        stim_t s;
        int step;
        tick();
        tick();
        expQ.push_back(obs_t'(7'b0));
        got = obs(1'b0); want = expQ.pop_front(); checks++;
        if (got !== want) $display("[TB] FAIL reset_init0 got %b want %b", got, want); else passed++;
        expQ.push_back(obs_t'(7'b0));
        got = obs(1'b1); want = expQ.pop_front(); checks++;
        if (got !== want) $display("[TB] FAIL reset_init1 got %b want %b", got, want); else passed++;
        reset = 1'b0;
        plan(1, 4'd7, 0, 0, 0, 4'd7, 0, 0, 0);
        plan(0, 4'd0, 1, 0, 0, 4'd7, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd6, 0, 1, 0);
        step = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            {load, load_value, start, pause, ack} = s;
            expQ.push_back(planQ.pop_front());
            tick();
            got = obs(1'b0); want = expQ.pop_front(); checks++;
            if (got !== want) $display("[TB] FAIL reset_pre step %0d got %b want %b", step, got, want); else passed++;
            step++;
        end
        // Asynchronous reset mid-RUN: outputs must clear with no clock edge.
        reset = 1'b1;
        #1;
        expQ.push_back(obs_t'(7'b0));
        got = obs(1'b0); want = expQ.pop_front(); checks++;
        if (got !== want) $display("[TB] FAIL reset_async got %b want %b", got, want); else passed++;
        #1;
        reset = 1'b0;
        plan(0, 4'd0, 1, 0, 0, 4'd0, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1);
        plan(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
        step = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            {load, load_value, start, pause, ack} = s;
            expQ.push_back(planQ.pop_front());
            tick();
            got = obs(1'b0); want = expQ.pop_front(); checks++;
            if (got !== want) $display("[TB] FAIL reset_post step %0d got %b want %b", step, got, want); else passed++;
            step++;
        end
        // Reload register was cleared too, so the auto-reload copy expires every edge at 0.
        expQ.push_back(obs_t'({4'd0, 1'b1, 1'b1, 1'b0}));
        got = obs(1'b1); want = expQ.pop_front(); checks++;
        if (got !== want) $display("[TB] FAIL reset_reload got %b want %b", got, want); else passed++;
        ack = 1'b0;
    endtask

    task automatic test_countdown();
        obs_t got, want;
        stim_t s;
        int step;
        plan(1, 4'd5, 0, 0, 0, 4'd5, 0, 0, 0);
        plan(0, 4'd0, 1, 0, 0, 4'd5, 0, 1, 0);
        for (int i = 4; i >= 0; i--) plan(0, 4'd0, 0, 0, 0, 4'(i), 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1);
        plan(0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 1);
        plan(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
        plan(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        step = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            {load, load_value, start, pause, ack} = s;
            expQ.push_back(planQ.pop_front());
            tick();
            got = obs(1'b0); want = expQ.pop_front(); checks++;
            if (got !== want) $display("[TB] FAIL countdown step %0d got %b want %b", step, got, want); else passed++;
            step++;
        end
    endtask

    task automatic test_autoreload();
        obs_t got, want;
        stim_t s;
        int step;
        plan(1, 4'd3, 0, 0, 0, 4'd3, 0, 0, 0);
        plan(0, 4'd0, 1, 0, 0, 4'd3, 0, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            if (k % 4 == 0) plan(0, 4'd0, 0, 0, 0, 4'd3, 1, 1, 0);
            else            plan(0, 4'd0, 0, 0, 0, 4'(3 - (k % 4)), 0, 1, 0);
        end
        step = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            {load, load_value, start, pause, ack} = s;
            expQ.push_back(planQ.pop_front());
            tick();
            got = obs(1'b1); want = expQ.pop_front(); checks++;
            if (got !== want) $display("[TB] FAIL autoreload step %0d got %b want %b", step, got, want); else passed++;
            step++;
        end
    endtask

    task automatic test_pause();
        obs_t got, want;
        stim_t s;
        int step;
        plan(1, 4'd4, 0, 0, 0, 4'd4, 0, 0, 0);
        plan(0, 4'd0, 1, 0, 0, 4'd4, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd3, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd2, 0, 1, 0);
        plan(0, 4'd0, 0, 1, 0, 4'd2, 0, 1, 0);
        plan(0, 4'd0, 0, 1, 0, 4'd2, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd2, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd1, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1);
        // Pause coinciding with the expiry edge defers the expiry.
        plan(1, 4'd1, 0, 0, 0, 4'd1, 0, 0, 0);
        plan(0, 4'd0, 1, 0, 0, 4'd1, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0);
        plan(0, 4'd0, 0, 1, 0, 4'd0, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1);
        step = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            {load, load_value, start, pause, ack} = s;
            expQ.push_back(planQ.pop_front());
            tick();
            got = obs(1'b0); want = expQ.pop_front(); checks++;
            if (got !== want) $display("[TB] FAIL pause step %0d got %b want %b", step, got, want); else passed++;
            step++;
        end
    endtask

    task automatic test_load_override();
        obs_t got, want;
        stim_t s;
        int step;
        plan(1, 4'd9, 0, 0, 0, 4'd9, 0, 0, 1);
        plan(0, 4'd0, 1, 0, 0, 4'd9, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd8, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd7, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd6, 0, 1, 0);
        plan(1, 4'd2, 1, 0, 0, 4'd2, 0, 0, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd2, 0, 0, 0);
        plan(0, 4'd0, 1, 0, 0, 4'd2, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd1, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1);
        step = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            {load, load_value, start, pause, ack} = s;
            expQ.push_back(planQ.pop_front());
            tick();
            got = obs(1'b0); want = expQ.pop_front();
            // The load edge clears done even though the previous test left it set.
            if (step == 0) want.done = 1'b0;
            checks++;
            if (got !== want) $display("[TB] FAIL load_override step %0d got %b want %b", step, got, want); else passed++;
            step++;
        end
    endtask

    task automatic test_boundaries();
        obs_t got, want;
        stim_t s;
        int step;
        plan(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
        plan(1, 4'd15, 0, 0, 0, 4'd15, 0, 0, 0);
        plan(0, 4'd0, 1, 0, 0, 4'd15, 0, 1, 0);
        for (int i = 14; i >= 0; i--) plan(0, 4'd0, 0, 0, 0, 4'(i), 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1);
        plan(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
        plan(1, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        plan(0, 4'd0, 1, 0, 0, 4'd0, 0, 1, 0);
        plan(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1);
        plan(0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 1);
        plan(1, 4'd6, 0, 0, 0, 4'd6, 0, 0, 0);
        step = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            {load, load_value, start, pause, ack} = s;
            expQ.push_back(planQ.pop_front());
            tick();
            got = obs(1'b0); want = expQ.pop_front(); checks++;
            if (got !== want) $display("[TB] FAIL boundaries step %0d got %b want %b", step, got, want); else passed++;
            step++;
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_autoreload();
        test_pause();
        test_load_override();
        test_boundaries();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
